// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor scan controller.
//   scan_state_t    : scan sequencer states
//   CH_MOIST/CH_TEMP: ADC channel select codes
//   *_TH_D          : default alert thresholds
package sensor_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_MOIST = 3'd1,
        REQ_TEMP  = 3'd2,
        UPDATE    = 3'd3,
        WAIT      = 3'd4
    } scan_state_t;

    localparam logic CH_MOIST = 1'b0;
    localparam logic CH_TEMP  = 1'b1;

    localparam logic [7:0] MOIST_LOW_TH_D = 8'd30;
    localparam logic [7:0] TEMP_HIGH_TH_D = 8'd70;

endpackage

// File: rtl/sensor_scan_controller_if.sv
// Request/acknowledge link to the shared 8-bit sensor ADC.
//   adc_req  : conversion request (controller -> ADC)
//   adc_ch   : channel select, stable while adc_req is high
//   adc_ack  : conversion done, adc_data valid in the same cycle
//   adc_data : conversion result
interface sensor_scan_controller_if;

    logic       adc_req;
    logic       adc_ch;
    logic       adc_ack;
    logic [7:0] adc_data;

    modport master (output adc_req, output adc_ch, input adc_ack, input adc_data);
    modport slave  (input adc_req, input adc_ch, output adc_ack, output adc_data);

endinterface

// File: rtl/sensor_scan_controller_alert_debounce.sv
// Per-channel alert debouncer.
//   clk, rst_n   : clock, async active-low reset
//   sample_en    : a fresh sample of this channel is being judged this cycle
//   out_of_range : that sample violates its threshold
//   alert        : high once DEBOUNCE_N consecutive samples were out of range
module alert_debounce #(
    parameter int unsigned DEBOUNCE_N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic out_of_range,
    output logic alert
);

    localparam int CW = $clog2(DEBOUNCE_N + 1);

    logic [CW-1:0] cnt;

    // Saturating run-length of out-of-range samples; any good sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sample_en) begin
            if (!out_of_range)
                cnt <= '0;
            else if (cnt != CW'(DEBOUNCE_N))
                cnt <= cnt + CW'(1);
        end
    end

    assign alert = (cnt == CW'(DEBOUNCE_N));

endmodule

// File: rtl/sensor_scan_controller.sv
// Periodic two-channel sensor scanner (moisture then IR temperature).
//   clk, rst_n      : clock, async active-low reset
//   enable          : scanning enabled
//   err_clr         : clears adc_timeout_err (a coincident timeout wins)
//   adc             : ADC request/ack link (master side)
//   moisture_level  : last good moisture sample
//   temp_IR         : last good temperature sample
//   sample_valid    : one-cycle pulse at scan completion
//   moisture_alert  : debounced low-moisture alert
//   temp_alert      : debounced over-temperature alert
//   adc_timeout_err : sticky, an ADC request went unanswered
module sensor_scan_controller
    import sensor_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 64,
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned DEBOUNCE_N    = 3,
    parameter logic [7:0]  MOIST_LOW_TH  = MOIST_LOW_TH_D,
    parameter logic [7:0]  TEMP_HIGH_TH  = TEMP_HIGH_TH_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      err_clr,
    sensor_scan_controller_if.master  adc,
    output logic [7:0]                moisture_level,
    output logic [7:0]                temp_IR,
    output logic                      sample_valid,
    output logic                      moisture_alert,
    output logic                      temp_alert,
    output logic                      adc_timeout_err
);

    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    scan_state_t   state;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] to_cnt;
    logic          got_moist;
    logic          got_temp;

    logic ack_hit;
    logic to_hit;
    logic start_scan;

    // Ack only counts while a request is outstanding.
    assign ack_hit = adc.adc_req & adc.adc_ack;
    // Last permitted request cycle passing without ack.
    assign to_hit  = adc.adc_req & ~adc.adc_ack & (to_cnt == TW'(TIMEOUT - 1));

    assign start_scan = enable & ((state == IDLE) | ((state == WAIT) & (period_cnt == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            period_cnt     <= '0;
            to_cnt         <= '0;
            got_moist      <= 1'b0;
            got_temp       <= 1'b0;
            adc.adc_req    <= 1'b0;
            adc.adc_ch     <= CH_MOIST;
            moisture_level <= '0;
            temp_IR        <= '0;
        end else if (start_scan) begin
            state       <= REQ_MOIST;
            period_cnt  <= PW'(SAMPLE_PERIOD - 1);
            to_cnt      <= '0;
            got_moist   <= 1'b0;
            got_temp    <= 1'b0;
            adc.adc_req <= 1'b1;
            adc.adc_ch  <= CH_MOIST;
        end else begin
            if (state != IDLE)
                period_cnt <= period_cnt - PW'(1);
            case (state)
                REQ_MOIST: begin
                    if (ack_hit || to_hit) begin
                        if (ack_hit) begin
                            moisture_level <= adc.adc_data;
                            got_moist      <= 1'b1;
                        end
                        state       <= REQ_TEMP;
                        adc.adc_req <= 1'b0;
                        adc.adc_ch  <= CH_TEMP;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                REQ_TEMP: begin
                    // First cycle of this state is the mandatory idle gap
                    // between the two requests; the request rises after it.
                    if (!adc.adc_req) begin
                        adc.adc_req <= 1'b1;
                    end else if (ack_hit || to_hit) begin
                        if (ack_hit) begin
                            temp_IR  <= adc.adc_data;
                            got_temp <= 1'b1;
                        end
                        state       <= UPDATE;
                        adc.adc_req <= 1'b0;
                        adc.adc_ch  <= CH_MOIST;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                UPDATE: state <= WAIT;
                WAIT: begin
                    // Period boundary with enable low: park in IDLE.
                    if (period_cnt == '0) begin
                        state      <= IDLE;
                        period_cnt <= PW'(SAMPLE_PERIOD - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            adc_timeout_err <= 1'b0;
        else if (to_hit)
            adc_timeout_err <= 1'b1;
        else if (err_clr)
            adc_timeout_err <= 1'b0;
    end

    assign sample_valid = (state == UPDATE);

    // Debounce judges the registered samples during UPDATE; a timed-out
    // channel gets no sample_en, so its history is left untouched.
    logic [1:0] ch_sample_en;
    logic [1:0] ch_oor;
    logic [1:0] ch_alert;

    assign ch_sample_en[CH_MOIST] = sample_valid & got_moist;
    assign ch_sample_en[CH_TEMP]  = sample_valid & got_temp;
    assign ch_oor[CH_MOIST]       = (moisture_level < MOIST_LOW_TH);
    assign ch_oor[CH_TEMP]        = (temp_IR > TEMP_HIGH_TH);

    for (genvar g = 0; g < 2; g++) begin : g_deb
        alert_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_en    (ch_sample_en[g]),
            .out_of_range (ch_oor[g]),
            .alert        (ch_alert[g])
        );
    end

    assign moisture_alert = ch_alert[CH_MOIST];
    assign temp_alert     = ch_alert[CH_TEMP];

endmodule
